// File: rtl/fft_mem_arbiter.sv
// Single-port FFT sample memory arbiter: engine vs. host, one access per cycle,
// tagged read return after a fixed latency, bounded host starvation.
module fft_mem_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 16,
    parameter int DEPTH         = 2048,
    parameter int RD_LAT        = 1,
    parameter int HOST_MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              fft_busy_i,
    input  logic              eng_req_i,
    input  logic              eng_we_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    input  logic [DATA_W-1:0] eng_wdata_i,
    output logic              eng_gnt_o,
    output logic              eng_rvalid_o,
    output logic [DATA_W-1:0] eng_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              mem_write_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              addr_err_o,
    output logic [7:0]        err_count_o
);

    localparam int              WAIT_W   = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic            OWN_ENG  = 1'b0;
    localparam logic            OWN_HOST = 1'b1;

    logic              r_last_owner;
    logic [WAIT_W-1:0] r_host_wait;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_own;
    logic [RD_LAT-1:0] r_tag_oor;
    logic              r_addr_err;
    logic [7:0]        r_err_count;

    logic              w_eng_gnt;
    logic              w_host_gnt;
    logic              w_any_gnt;
    logic              w_host_starved;
    logic              w_sel_we;
    logic              w_sel_oor;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_ret_vld;
    logic              w_ret_own;
    logic [DATA_W-1:0] w_ret_data;

    assign w_host_starved = (r_host_wait >= WAIT_W'(HOST_MAX_WAIT));
    assign w_any_gnt      = w_eng_gnt | w_host_gnt;

    // Grant decision; a starved host overrides both RR and engine priority on a tie
    always_comb begin
        w_eng_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!reset_n_i) begin
            w_eng_gnt  = 1'b0;
            w_host_gnt = 1'b0;
        end else if (eng_req_i && host_req_i) begin
            if (w_host_starved) begin
                w_host_gnt = 1'b1;
            end else if (fft_busy_i) begin
                w_eng_gnt = 1'b1;
            end else if (r_last_owner == OWN_HOST) begin
                w_eng_gnt = 1'b1;
            end else begin
                w_host_gnt = 1'b1;
            end
        end else if (eng_req_i) begin
            w_eng_gnt = 1'b1;
        end else if (host_req_i) begin
            w_host_gnt = 1'b1;
        end else begin
            w_eng_gnt  = 1'b0;
            w_host_gnt = 1'b0;
        end
    end

    // Select the granted requester's access; everything is zero without a grant
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_eng_gnt) begin
            w_sel_we    = eng_we_i;
            w_sel_addr  = eng_addr_i;
            w_sel_wdata = eng_wdata_i;
        end else if (w_host_gnt) begin
            w_sel_we    = host_we_i;
            w_sel_addr  = host_addr_i;
            w_sel_wdata = host_wdata_i;
        end else begin
            w_sel_we    = 1'b0;
            w_sel_addr  = '0;
            w_sel_wdata = '0;
        end
        w_sel_oor = w_any_gnt & ({1'b0, w_sel_addr} >= LP_DEPTH);
    end

    // Out-of-range accesses are granted but never reach the memory array
    assign mem_en_o    = w_any_gnt & ~w_sel_oor;
    assign mem_write_o = w_any_gnt & w_sel_we & ~w_sel_oor;
    assign mem_addr_o  = w_sel_addr;
    assign mem_data_o  = w_sel_wdata;

    // Arbitration history: last owner and host hold-off counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last_owner <= OWN_HOST;
            r_host_wait  <= '0;
        end else begin
            if (w_eng_gnt) begin
                r_last_owner <= OWN_ENG;
            end else if (w_host_gnt) begin
                r_last_owner <= OWN_HOST;
            end else begin
                r_last_owner <= r_last_owner;
            end
            if (host_req_i && !w_host_gnt) begin
                if (!w_host_starved) begin
                    r_host_wait <= r_host_wait + WAIT_W'(1);
                end else begin
                    r_host_wait <= r_host_wait;
                end
            end else begin
                r_host_wait <= '0;
            end
        end
    end

    // Out-of-range pulse and saturating error counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr_err  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_addr_err <= w_sel_oor;
            if (w_sel_oor && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

    assign addr_err_o  = r_addr_err;
    assign err_count_o = r_err_count;

    // Read tag pipeline, aligned with the memory read latency
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
            r_tag_oor <= '0;
        end else begin
            r_tag_vld[0] <= w_any_gnt & ~w_sel_we;
            r_tag_own[0] <= w_host_gnt;
            r_tag_oor[0] <= w_sel_oor;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
                r_tag_oor[i] <= r_tag_oor[i-1];
            end
        end
    end

    assign w_ret_vld  = r_tag_vld[RD_LAT-1];
    assign w_ret_own  = r_tag_own[RD_LAT-1];
    assign w_ret_data = r_tag_oor[RD_LAT-1] ? '0 : mem_data_i;

    // Steer returning read data to its owner only
    always_comb begin
        eng_rvalid_o  = 1'b0;
        eng_rdata_o   = '0;
        host_rvalid_o = 1'b0;
        host_rdata_o  = '0;
        if (w_ret_vld && (w_ret_own == OWN_HOST)) begin
            host_rvalid_o = 1'b1;
            host_rdata_o  = w_ret_data;
        end else if (w_ret_vld) begin
            eng_rvalid_o = 1'b1;
            eng_rdata_o  = w_ret_data;
        end else begin
            eng_rvalid_o  = 1'b0;
            host_rvalid_o = 1'b0;
        end
    end

    assign eng_gnt_o  = w_eng_gnt;
    assign host_gnt_o = w_host_gnt;

endmodule

// File: doc/fft_mem_arbiter.md
Name: fft_mem_arbiter

Overview:
- Arbitrates the single-port FFT sample memory (DEPTH x 32-bit words, 2048 by default) between two requesters: the FFT engine and the host register/APB bridge.
- Sits between the requesters and the memory interface's FFT-engine memory port.
- Grants one access per cycle and returns read data tagged to the owning requester after a fixed read latency.
- Gives the engine priority while an FFT is busy, with a bounded host starvation limit.

Parameters:
- DATA_W, 32, memory word width
- ADDR_W, 16, requester and memory address width
- DEPTH, 2048, valid word locations; addresses >= DEPTH are out of range
- RD_LAT, 1, memory read latency in cycles (1..4)
- HOST_MAX_WAIT, 16, maximum number of cycles the host may be held off while fft_busy_i=1

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- fft_busy_i  in  1  FFT engine running; selects engine-priority mode
- eng_req_i  in  1  engine access request, held until granted
- eng_we_i  in  1  engine write (1) / read (0)
- eng_addr_i  in  ADDR_W  engine word address
- eng_wdata_i  in  DATA_W  engine write data
- eng_gnt_o  out  1  engine request accepted this cycle
- eng_rvalid_o  out  1  engine read data valid
- eng_rdata_o  out  DATA_W  engine read data
- host_req_i, host_we_i, host_addr_i, host_wdata_i  in  1/1/ADDR_W/DATA_W  host request; same meaning as the engine signals
- host_gnt_o, host_rvalid_o, host_rdata_o  out  1/1/DATA_W  host grant and read return
- mem_write_o  out  1  memory write strobe
- mem_en_o  out  1  memory access strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data, valid RD_LAT cycles after a read with mem_en_o=1
- addr_err_o  out  1  one-cycle pulse when a granted access is out of range
- err_count_o  out  8  saturating count of out-of-range accesses

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - All outputs 0; last_owner=HOST (so the engine wins the first tie).
  - Wait counter 0; read tag pipeline cleared.
  - Reads in flight at reset are dropped and return no rvalid.
- Transfer occurs when req and gnt are both 1 in the same cycle.
- gnt is combinational from the current req inputs and registered state.
- At most one gnt is asserted per cycle.
- Arbitration modes:
  - RR (fft_busy_i=0): if both requesters request, grant the one that is not last_owner. A single requester is granted immediately.
  - ENG_PRIO (fft_busy_i=1): the engine wins every tie.
    - host_wait increments each cycle host_req_i=1 and host_gnt_o=0.
    - When host_wait reaches HOST_MAX_WAIT, the host wins the next tie regardless of mode; host_wait then clears.
  - host_wait clears whenever the host is granted or host_req_i=0.
  - last_owner updates on every grant.
- Memory side:
  - mem_en_o/mem_write_o/mem_addr_o/mem_data_o are driven combinationally from the granted requester.
  - All memory outputs are 0 when there is no grant.
- Out-of-range access (addr >= DEPTH):
  - Still granted; mem_en_o and mem_write_o are held at 0.
  - addr_err_o pulses on the following cycle; err_count_o increments and saturates at 255.
  - An out-of-range read still returns, RD_LAT cycles later, with rvalid=1 and rdata=0.
- Read return:
  - An RD_LAT-deep shift register carries {valid, owner, oor} for each granted read.
  - At depth RD_LAT, the owner's rvalid pulses for one cycle with rdata=mem_data_i (or 0 if oor).
  - The non-owner's rdata stays 0.
  - Reads are fully pipelined: back-to-back reads give back-to-back rvalid pulses in grant order.
- Writes produce no rvalid.
- Read-after-write to the same address on consecutive grants returns the new data (memory is write-first).
- fft_busy_i changing mid-stream affects only the next arbitration decision; in-flight reads are unaffected.
- Requester rules: a requester must hold req/we/addr/wdata stable until granted. Changing them before grant is allowed; the value present at the grant cycle is used.

Test Plan:
- Reset: hold reset_n_i=0 with both req=1 -> all gnt/rvalid/mem_* = 0. Release -> the first tie grants the engine.
- RR mode, fft_busy_i=0, both requesting reads continuously -> grants alternate E,H,E,H. Each rvalid arrives RD_LAT=1 cycle after its grant at the correct owner.
- Host write/read: host writes 0xA5A5A5A5 to 0x0000 and 0x5A5A5A5A to 0x0001, then reads both -> host_rdata_o = 0xA5A5A5A5, then 0x5A5A5A5A; eng_rvalid_o stays 0.
- Starvation: fft_busy_i=1, eng_req_i held 1, host reads 0x07FF (after a host write of 0xDEADBEEF there) -> host is granted exactly on cycle 17 of waiting and receives 0xDEADBEEF; the engine gets every other grant.
- Out of range: engine writes then reads 0x0800 -> mem_en_o=0, two addr_err_o pulses, err_count_o=2, read returns rvalid=1 with data 0. Forcing 300 bad accesses -> err_count_o saturates at 255.
- Reset mid-read: assert reset_n_i the cycle after a read grant -> no rvalid after reset release; the next transaction behaves normally.
